// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: two cascaded half-subtractor stages per bit, LSB first,
// with a registered borrow. Operands are loaded on start; the result is held until the next one.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             busy_next;
  logic             done_next;
  logic             d1;
  logic             b1;
  logic             d;
  logic             b2;
  logic             last;

  // Two half-subtractor stages: operand bits first, then the running borrow.
  always_comb begin
    d1   = sa[0] ^ sb[0];
    b1   = ~sa[0] & sb[0];
    d    = d1 ^ br;
    b2   = ~d1 & br;
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track the state register exactly.
  always_comb begin
    busy_next = (state_next == SHIFT);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            sd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          sd  <= {d, sd[WIDTH-1:1]};
          br  <= b1 | b2;
          cnt <= cnt + CW'(1);
          // The MSB edge publishes the result; it then holds until the next completion.
          if (last) begin
            diff       <= {d, sd[WIDTH-1:1]};
            borrow_out <= b1 | b2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=5 against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start5;
  logic [7:0] a8, b8, diff8;
  logic [4:0] a5, b5, diff5;
  logic       busy8, done8, bo8;
  logic       busy5, done5, bo5;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] prev8 = '0;
  logic [4:0] prev5 = '0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .a(a5), .b(b5),
    .busy(busy5), .done(done5), .diff(diff5), .borrow_out(bo5)
  );

  function automatic logic [7:0] ref_diff8(input int x, input int y);
    return 8'((x - y + 256) % 256);
  endfunction

  function automatic logic [4:0] ref_diff5(input int x, input int y);
    return 5'((x - y + 32) % 32);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE; scrambles a/b after acceptance and returns observations.
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, output int lat, output int bcnt,
                     output logic [7:0] d_early, output logic [7:0] d_out, output logic bo_out,
                     output logic busy_at_done, output logic done_after);
    a8 = ai; b8 = bi; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    d_early = diff8; lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      tick();
      a8 = 8'($urandom); b8 = 8'($urandom);
      lat++;
    end
    d_out = diff8; bo_out = bo8; busy_at_done = busy8;
    tick();
    done_after = done8;
  endtask

  task automatic op5(input logic [4:0] ai, input logic [4:0] bi, output int lat,
                     output logic [4:0] d_early, output logic [4:0] d_out, output logic bo_out);
    a5 = ai; b5 = bi; start5 = 1'b1;
    tick();
    start5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom);
    d_early = diff5; lat = 0;
    while (!done5 && lat < 40) begin
      tick();
      lat++;
    end
    d_out = diff5; bo_out = bo5;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b1; start5 = 1'b1;
    a8 = 8'd9; b8 = 8'd1; a5 = 5'd3; b5 = 5'd1;
    tick(); tick();
    start8 = 1'b0; start5 = 1'b0; rst_n = 1'b1;
    n_cmp++;
    if ({busy8, done8, diff8, bo8} !== 11'd0) begin
      n_bad++; $display("FAIL reset8 got busy=%b done=%b diff=%0d bo=%b exp all 0", busy8, done8, diff8, bo8);
    end
    n_cmp++;
    if ({busy5, done5, diff5, bo5} !== 8'd0) begin
      n_bad++; $display("FAIL reset5 got busy=%b done=%b diff=%0d bo=%b exp all 0", busy5, done5, diff5, bo5);
    end
    tick();
    n_cmp++;
    if (busy8 !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_start busy got %b exp 0", busy8);
    end
    prev8 = '0; prev5 = '0;
  endtask

  task automatic test_basic();
    int lat, bcnt; logic [7:0] de, dq; logic bq, bad, da;
    op8(8'd5, 8'd3, lat, bcnt, de, dq, bq, bad, da);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency got %0d exp 8", lat); end
    n_cmp++; if (bcnt !== 8) begin n_bad++; $display("FAIL basic_busy_cycles got %0d exp 8", bcnt); end
    n_cmp++; if (dq !== 8'd2) begin n_bad++; $display("FAIL basic_diff got %0d exp 2", dq); end
    n_cmp++; if (bq !== 1'b0) begin n_bad++; $display("FAIL basic_borrow got %b exp 0", bq); end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL basic_busy_in_done got %b exp 0", bad); end
    n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b exp 0", da); end
    n_cmp++; if (de !== prev8) begin n_bad++; $display("FAIL basic_hold got %0d exp %0d", de, prev8); end
    prev8 = 8'd2;
  endtask

  task automatic test_boundary();
    logic [7:0] ta [6] = '{8'd3, 8'd0, 8'd255, 8'd0, 8'd255, 8'd128};
    logic [7:0] tb [6] = '{8'd5, 8'd1, 8'd255, 8'd0, 8'd0,   8'd129};
    int lat, bcnt; logic [7:0] de, dq, ed; logic bq, bad, da;
    for (int i = 0; i < 6; i++) begin
      op8(ta[i], tb[i], lat, bcnt, de, dq, bq, bad, da);
      ed = ref_diff8(int'(ta[i]), int'(tb[i]));
      n_cmp++;
      if (dq !== ed || bq !== (ta[i] < tb[i])) begin
        n_bad++; $display("FAIL boundary a=%0d b=%0d got diff=%0d bo=%b exp diff=%0d bo=%b",
                          ta[i], tb[i], dq, bq, ed, ta[i] < tb[i]);
      end
      n_cmp++;
      if (de !== prev8) begin n_bad++; $display("FAIL boundary_hold got %0d exp %0d", de, prev8); end
      prev8 = ed;
    end
    // Full-scale subtrahend from zero: result 1 with borrow.
    op8(8'd0, 8'd255, lat, bcnt, de, dq, bq, bad, da);
    n_cmp++;
    if (dq !== 8'd1 || bq !== 1'b1) begin
      n_bad++; $display("FAIL boundary_0_minus_255 got diff=%0d bo=%b exp diff=1 bo=1", dq, bq);
    end
    prev8 = 8'd1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa, pb, ca, cb;
    logic pbusy = 1'b0, have = 1'b0;
    int last_acc = 0, ndone = 0, cyc = 0;
    start8 = 1'b1;
    while (ndone < 5 && cyc < 80) begin
      pa = 8'($urandom); pb = 8'($urandom);
      a8 = pa; b8 = pb;
      tick();
      cyc++;
      if (busy8 && !pbusy) begin
        if (have) begin
          n_cmp++;
          if (cyc - last_acc !== 10) begin
            n_bad++; $display("FAIL b2b_spacing got %0d exp 10", cyc - last_acc);
          end
        end
        n_cmp++;
        if (diff8 !== prev8) begin n_bad++; $display("FAIL b2b_hold got %0d exp %0d", diff8, prev8); end
        ca = pa; cb = pb; last_acc = cyc; have = 1'b1;
      end
      if (done8) begin
        n_cmp++;
        if (diff8 !== ref_diff8(int'(ca), int'(cb)) || bo8 !== (ca < cb)) begin
          n_bad++; $display("FAIL b2b_result a=%0d b=%0d got diff=%0d bo=%b exp diff=%0d bo=%b",
                            ca, cb, diff8, bo8, ref_diff8(int'(ca), int'(cb)), ca < cb);
        end
        prev8 = ref_diff8(int'(ca), int'(cb));
        ndone++;
      end
      pbusy = busy8;
    end
    start8 = 1'b0;
    n_cmp++;
    if (ndone < 5) begin n_bad++; $display("FAIL b2b_timeout got %0d dones exp 5", ndone); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bcnt; logic [7:0] de, dq; logic bq, bad, da, seen = 1'b0;
    a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({busy8, done8, diff8, bo8} !== 11'd0) begin
      n_bad++; $display("FAIL midreset got busy=%b done=%b diff=%0d bo=%b exp all 0", busy8, done8, diff8, bo8);
    end
    repeat (12) begin
      tick();
      if (done8) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_done got %b exp 0", seen); end
    prev8 = '0; prev5 = '0;
    op8(8'd200, 8'd100, lat, bcnt, de, dq, bq, bad, da);
    n_cmp++;
    if (dq !== 8'd100 || bq !== 1'b0 || de !== 8'd0) begin
      n_bad++; $display("FAIL midreset_recover got diff=%0d bo=%b early=%0d exp 100 0 0", dq, bq, de);
    end
    prev8 = 8'd100;
  endtask

  task automatic test_random8();
    int lat, bcnt; logic [7:0] ai, bi, de, dq, ed; logic bq, bad, da;
    for (int i = 0; i < 1000; i++) begin
      ai = 8'($urandom); bi = (i % 16 == 0) ? ai : 8'($urandom);
      op8(ai, bi, lat, bcnt, de, dq, bq, bad, da);
      ed = ref_diff8(int'(ai), int'(bi));
      n_cmp++;
      if (dq !== ed || bq !== (ai < bi) || lat !== 8 || de !== prev8) begin
        n_bad++; $display("FAIL rand8 a=%0d b=%0d got diff=%0d bo=%b lat=%0d early=%0d exp %0d %b 8 %0d",
                          ai, bi, dq, bq, lat, de, ed, ai < bi, prev8);
      end
      prev8 = ed;
    end
  endtask

  task automatic test_random5();
    int lat; logic [4:0] ai, bi, de, dq, ed; logic bq;
    for (int i = 0; i < 1000; i++) begin
      ai = 5'($urandom); bi = 5'($urandom);
      op5(ai, bi, lat, de, dq, bq);
      ed = ref_diff5(int'(ai), int'(bi));
      n_cmp++;
      if (dq !== ed || bq !== (ai < bi) || lat !== 5 || de !== prev5) begin
        n_bad++; $display("FAIL rand5 a=%0d b=%0d got diff=%0d bo=%b lat=%0d early=%0d exp %0d %b 5 %0d",
                          ai, bi, dq, bq, lat, de, ed, ai < bi, prev5);
      end
      prev5 = ed;
    end
  endtask

  initial begin
    rst_n = 1'b0; start8 = 1'b0; start5 = 1'b0;
    a8 = '0; b8 = '0; a5 = '0; b5 = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    fork
      test_random8();
      test_random5();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
